// File: rtl/prbs_pkg.sv
// prbs_pkg: mode/state types, per-mode lengths and tap masks, and the
// parallel multi-step LFSR advance shared by the PRBS source.
package prbs_pkg;

   typedef enum logic [1:0] {
      M_PRBS7  = 2'd0,
      M_PRBS15 = 2'd1,
      M_PRBS23 = 2'd2,
      M_PRBS31 = 2'd3
   } prbs_mode_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2
   } prbs_state_e;

   localparam int SW   = 31;
   localparam int MAXW = 64;

   localparam int L_PRBS7  = 7;
   localparam int L_PRBS15 = 15;
   localparam int L_PRBS23 = 23;
   localparam int L_PRBS31 = 31;

   typedef struct packed {
      logic [MAXW-1:0] word;
      logic [SW-1:0]   state;
   } prbs_adv_t;

   function automatic logic [SW-1:0] len_mask(prbs_mode_e m);
      unique case (m)
         M_PRBS7:  return SW'((64'd1 << L_PRBS7) - 64'd1);
         M_PRBS15: return SW'((64'd1 << L_PRBS15) - 64'd1);
         M_PRBS23: return SW'((64'd1 << L_PRBS23) - 64'd1);
         default:  return SW'((64'd1 << L_PRBS31) - 64'd1);
      endcase
   endfunction

   function automatic logic [SW-1:0] msb_mask(prbs_mode_e m);
      unique case (m)
         M_PRBS7:  return SW'(64'd1 << (L_PRBS7 - 1));
         M_PRBS15: return SW'(64'd1 << (L_PRBS15 - 1));
         M_PRBS23: return SW'(64'd1 << (L_PRBS23 - 1));
         default:  return SW'(64'd1 << (L_PRBS31 - 1));
      endcase
   endfunction

   // Taps are the two polynomial exponents, as state bit indices.
   function automatic logic [SW-1:0] tap_mask(prbs_mode_e m);
      unique case (m)
         M_PRBS7:  return 31'h0000_0060;
         M_PRBS15: return 31'h0000_6000;
         M_PRBS23: return 31'h0042_0000;
         default:  return 31'h4800_0000;
      endcase
   endfunction

   // n serial steps: word[i] is the i-th bit out, state is what remains.
   function automatic prbs_adv_t prbs_advance(
      input logic [SW-1:0] s,
      input prbs_mode_e    m,
      input int            n
   );
      prbs_adv_t     r;
      logic [SW-1:0] st;
      logic [SW-1:0] lm;
      logic [SW-1:0] tm;
      logic [SW-1:0] mm;
      logic          fb;
      lm     = len_mask(m);
      tm     = tap_mask(m);
      mm     = msb_mask(m);
      st     = s & lm;
      fb     = 1'b0;
      r.word = '0;
      for (int i = 0; i < MAXW; i++) begin
         if (i < n) begin
            r.word[i] = |(st & mm);
            fb        = ^(st & tm);
            st        = {st[SW-2:0], fb} & lm;
         end
      end
      r.state = st;
      return r;
   endfunction

endpackage

// File: rtl/prbs_lfsr_step.sv
// prbs_lfsr_step: combinational WIDTH-step advance of the Fibonacci LFSR
// for the selected polynomial.
module prbs_lfsr_step
   import prbs_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [SW-1:0]    i_state,
   input  prbs_mode_e       i_mode,
   output logic [WIDTH-1:0] o_word,
   output logic [SW-1:0]    o_state
);

   prbs_adv_t w_adv;
   logic      w_unused_word;

   always_comb begin
      w_adv   = prbs_advance(i_state, i_mode, WIDTH);
      o_word  = w_adv.word[WIDTH-1:0];
      o_state = w_adv.state;
   end

   assign w_unused_word = ^w_adv.word;

endmodule

// File: rtl/prbs_src.sv
// prbs_src: burst/continuous PRBS word source with valid/ready output.
// Optional error injection is enabled by PRBS_SRC_ERR_INJ_EN.
module prbs_src
   import prbs_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             stop,
   input  logic [1:0]       mode,
   input  logic [30:0]      seed,
   input  logic [CNT_W-1:0] burst_len,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] word_cnt
`ifdef PRBS_SRC_ERR_INJ_EN
  ,input  logic             err_inj,
   output logic [CNT_W-1:0] err_cnt
`endif
);

   prbs_state_e      r_state;
   prbs_state_e      w_next;
   prbs_mode_e       r_mode;
   logic [SW-1:0]    r_seed;
   logic [CNT_W-1:0] r_burst;
   logic [SW-1:0]    r_lfsr;
   logic [WIDTH-1:0] r_dout;
   logic             r_valid;
   logic             r_done;
   logic [CNT_W-1:0] r_cnt;
   logic             r_stop;

   logic             w_xfer;
   logic             w_stop;
   logic             w_last;
   logic             w_exit;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [SW-1:0]    w_seed_l;
   logic [SW-1:0]    w_seed_eff;
   logic [SW-1:0]    w_step_in;
   logic [SW-1:0]    w_step_state;
   logic [WIDTH-1:0] w_step_word;

   assign w_xfer    = r_valid & dout_ready;
   assign w_stop    = stop | r_stop;
   assign w_cnt_inc = r_cnt + 1'b1;
   assign w_last    = w_xfer && (r_burst != '0)
                      && (w_cnt_inc == r_burst);
   assign w_exit    = (r_state == S_RUN)
                      && (w_last || (w_xfer && w_stop)
                          || (!r_valid && w_stop));

   // A zero seed would lock the LFSR, so it is replaced by all-ones.
   assign w_seed_l   = r_seed & len_mask(r_mode);
   assign w_seed_eff = (w_seed_l == '0) ? len_mask(r_mode) : w_seed_l;
   assign w_step_in  = (r_state == S_LOAD) ? w_seed_eff : r_lfsr;

   prbs_lfsr_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_state (w_step_in),
      .i_mode  (r_mode),
      .o_word  (w_step_word),
      .o_state (w_step_state)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (start) w_next = S_LOAD;
         S_LOAD:  w_next = S_RUN;
         S_RUN:   if (w_exit) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // r_lfsr holds the state following the word currently in r_dout.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mode  <= M_PRBS7;
         r_seed  <= '0;
         r_burst <= '0;
         r_lfsr  <= '1;
         r_dout  <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         r_cnt   <= '0;
         r_stop  <= 1'b0;
      end else begin
         r_done <= w_exit;
         if (r_state == S_IDLE && start) begin
            r_mode  <= prbs_mode_e'(mode);
            r_seed  <= seed;
            r_burst <= burst_len;
         end
         if (r_state == S_IDLE || w_exit) r_stop <= 1'b0;
         else if (stop)                   r_stop <= 1'b1;
         if (r_state == S_LOAD) begin
            r_lfsr  <= w_step_state;
            r_dout  <= w_step_word;
            r_valid <= 1'b1;
            r_cnt   <= '0;
         end else if (r_state == S_RUN && w_xfer) begin
            r_lfsr <= w_step_state;
            r_dout <= w_step_word;
            r_cnt  <= w_cnt_inc;
            if (w_exit) r_valid <= 1'b0;
         end
      end
   end

   assign dout_valid = r_valid;
   assign busy       = (r_state == S_RUN);
   assign done       = r_done;
   assign word_cnt   = r_cnt;

`ifdef PRBS_SRC_ERR_INJ_EN
   logic             r_err_pend;
   logic [CNT_W-1:0] r_err_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_err_pend <= 1'b0;
         r_err_cnt  <= '0;
      end else if (w_xfer && r_err_pend) begin
         r_err_pend <= err_inj;
         r_err_cnt  <= r_err_cnt + 1'b1;
      end else if (err_inj) begin
         r_err_pend <= 1'b1;
      end
   end

   assign dout    = r_dout ^ WIDTH'(r_err_pend);
   assign err_cnt = r_err_cnt;
`else
   assign dout = r_dout;
`endif

endmodule

// File: doc/prbs_src.md
PRBS_SRC -- requirements
Module: prbs_src

Interface
REQ-001 Parameter WIDTH, default 8, output word width in bits (1..64).
REQ-002 Parameter CNT_W, default 16, width of burst_len and word_cnt.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to begin generation; honoured only in IDLE.
REQ-006 stop  in  1  request to end the run after the word currently presented.
REQ-007 mode  in  2  polynomial select, sampled on start: 0 PRBS7 x^7+x^6+1, 1 PRBS15 x^15+x^14+1, 2 PRBS23 x^23+x^18+1, 3 PRBS31 x^31+x^28+1.
REQ-008 seed  in  31  initial state; the low L bits are used (L = 7/15/23/31 per mode); sampled on start.
REQ-009 burst_len  in  CNT_W  words per run; 0 means continuous; sampled on start.
REQ-010 dout  out  WIDTH  PRBS word; dout[0] is the earliest serial bit.
REQ-011 dout_valid  out  1  dout holds a word available for transfer.
REQ-012 dout_ready  in  1  sink accepts; a transfer occurs when dout_valid && dout_ready.
REQ-013 busy  out  1  high in RUN.
REQ-014 done  out  1  one-cycle pulse on the cycle after the final transfer or stop completes.
REQ-015 word_cnt  out  CNT_W  transfers in the current/last run; wraps modulo 2^CNT_W.

Function
REQ-016 FSM states IDLE, LOAD, RUN; IDLE->LOAD on start; LOAD->RUN unconditionally; RUN->IDLE on the last transfer (word_cnt+1 == burst_len, burst_len != 0), or on a transfer with stop asserted or previously latched, or immediately when stop is seen while dout_valid is low.
REQ-017 LFSR is Fibonacci: serial output bit = s[L-1]; feedback = XOR of the tap bits shifted into s[0].
REQ-018 In LOAD: state <= seed[L-1:0], or all-ones if that slice is zero; the word counter clears.
REQ-019 dout_valid rises the cycle after LOAD (start at cycle N -> first valid word at N+2) and carries the first WIDTH serial bits of the seed.
REQ-020 The next word is computed as a WIDTH-step parallel advance in one cycle; the state advances only on a transfer.
REQ-021 While dout_valid && !dout_ready, dout stays stable and dout_valid stays high (no drop without transfer except via reset).
REQ-022 A stop is latched until it takes effect; start during LOAD/RUN is ignored; mode/seed/burst_len changes during a run are ignored.
REQ-023 word_cnt increments by 1 per transfer and holds its value in IDLE until the next LOAD.
REQ-024 Simultaneous stop and last burst transfer: single exit, single done pulse.

Reset
REQ-025 On reset_n low: state IDLE, LFSR all-ones, dout 0, dout_valid 0, busy 0, done 0, word_cnt 0, stop latch and error latch cleared; asserting it mid-run aborts without a done pulse.

Configuration
REQ-026 Macro PRBS_SRC_ERR_INJ_EN: when defined, adds input err_inj (1 bit) and output err_cnt (CNT_W bits); an err_inj pulse latches a pending flag that inverts dout[0] of the next transferred word (the LFSR is unaffected), then clears; err_cnt counts injected words and resets to 0.
REQ-027 Without PRBS_SRC_ERR_INJ_EN, neither port nor logic exists and dout is pure PRBS.

Structure
REQ-028 Package prbs_pkg holds the mode enum, per-mode lengths and tap masks, and the FSM state typedef.
REQ-029 The parallel next-state/output mask function lives in prbs_pkg; one sub-module, prbs_lfsr_step (combinational WIDTH-step advance for a selected mode), is instantiated once.

Verification
REQ-030 mode 0, seed 0x7F, WIDTH 8, burst_len 0, ready high -> dout 8'h7F, then 8'h20; the word sequence repeats after 127 words.
REQ-031 Same stimulus with ready low for 3 cycles at word 1 -> dout held at 8'h20 with valid high; the next word appears only after ready returns.
REQ-032 burst_len 4 -> exactly 4 transfers, done pulse, busy low, word_cnt 4; start during the run is ignored.
REQ-033 seed 0 in mode 3 -> behaviour identical to an all-ones seed; stop mid-run -> the pending word completes, then IDLE.
REQ-034 reset_n low mid-run -> all outputs reach their reset values asynchronously, with no done pulse.
REQ-035 With PRBS_SRC_ERR_INJ_EN, err_inj before the first word -> dout 8'h7E, then 8'h20 unaltered; err_cnt 1.
